// File: rtl/pool_kxk_stream_pkg.sv
// Shared definitions for the KxK streaming pooling block: reduction modes,
// pipeline tag struct and counter width helper.
package pool_kxk_stream_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef struct packed {
    logic sof;
    logic eof;
    logic mode;
  } pool_tag_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_kxk_stream_line_buffer.sv
// One-row delay line: dout is the word written IMG_W accepted pixels ago.
// Circular buffer, so contents never need clearing.
module pool_line_buffer
  import pool_kxk_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 299
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int AW = cnt_w(IMG_W);

  logic [DATA_WIDTH-1:0] mem [IMG_W];
  logic [AW-1:0]         ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == AW'(IMG_W-1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end

endmodule

// File: rtl/pool_kxk_stream.sv
// Streaming KxK max/min pooling over a raster-order image, fixed 2-clock latency
// from the window-completing pixel to pxl_out, with sof/eof frame markers.
module pool_kxk_stream
  import pool_kxk_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 299,
  parameter int IMG_H      = 299,
  parameter int K          = 3,
  parameter int S          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  sof_out,
  output logic                  eof_out
);
  localparam int OUT_W  = (IMG_W - K) / S + 1;
  localparam int OUT_H  = (IMG_H - K) / S + 1;
  localparam int CW     = cnt_w(IMG_W);
  localparam int RW     = cnt_w(IMG_H);
  localparam int PW     = cnt_w(S);
  localparam int LAST_C = K - 1 + (OUT_W - 1) * S;
  localparam int LAST_R = K - 1 + (OUT_H - 1) * S;

  if (K < 2 || S < 1 || IMG_W < K || IMG_H < K) begin : g_bad_params
    $error("pool_kxk_stream: illegal parameters K=%0d S=%0d IMG_W=%0d IMG_H=%0d", K, S, IMG_W, IMG_H);
  end

  typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_t;

  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic [PW-1:0]             col_ph, row_ph;
  logic                      mode_q;
  logic [DATA_WIDTH-1:0]     lb_in  [K-1];
  logic [DATA_WIDTH-1:0]     lb_out [K-1];
  logic [K-1:0][DATA_WIDTH-1:0] col_vec;
  win_t                      win, win_s1;
  pool_tag_t                 tag_s0, tag_s1;
  logic [1:0]                vld_pipe;
  logic                      hit, hit_sof, hit_eof;

  // col_vec[i] is row r-i at the current column; lb i delays row r-i by one line
  assign col_vec[0] = pxl_in;
  for (genvar i = 0; i < K-1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_in[i] = pxl_in;
    end else begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    assign col_vec[i+1] = lb_out[i];
    pool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W)) u_lb (
      .clk  (clk),
      .reset(reset),
      .en   (valid_in),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // Phase counters are zero exactly on stride-aligned columns/rows past K-1
  assign hit = valid_in && (col >= CW'(K-1)) && (row >= RW'(K-1))
            && (col_ph == '0) && (row_ph == '0);
  assign hit_sof = (col == CW'(K-1)) && (row == RW'(K-1));
  assign hit_eof = (col == CW'(LAST_C)) && (row == RW'(LAST_R));

  function automatic logic [DATA_WIDTH-1:0] reduce(input win_t w, input logic m);
    logic signed [DATA_WIDTH-1:0] acc, v;
    acc = $signed(w[0][0]);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        v = $signed(w[i][j]);
        if ((m == MODE_MIN) ? (v < acc) : (v > acc)) acc = v;
      end
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      col_ph    <= '0;
      row_ph    <= '0;
      mode_q    <= MODE_MAX;
      vld_pipe  <= '0;
      pxl_out   <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      if (valid_in) begin
        if (col == '0 && row == '0) mode_q <= mode;
        if (col == CW'(IMG_W-1)) begin
          col    <= '0;
          col_ph <= '0;
          if (row == RW'(IMG_H-1)) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row <= row + 1'b1;
            if (row >= RW'(K-1)) row_ph <= (row_ph == PW'(S-1)) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col >= CW'(K-1)) col_ph <= (col_ph == PW'(S-1)) ? '0 : col_ph + 1'b1;
        end
      end
      vld_pipe  <= {vld_pipe[0], hit};
      valid_out <= vld_pipe[1];
      sof_out   <= vld_pipe[1] && tag_s1.sof;
      eof_out   <= vld_pipe[1] && tag_s1.eof;
      if (vld_pipe[1]) pxl_out <= reduce(win_s1, tag_s1.mode);
    end
  end

  // Datapath registers carry no reset; vld_pipe gates everything they feed
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= col_vec[i];
      end
    end
    if (hit) tag_s0 <= '{sof: hit_sof, eof: hit_eof, mode: mode_q};
    if (vld_pipe[0]) begin
      win_s1 <= win;
      tag_s1 <= tag_s0;
    end
  end

endmodule

// File: tb/tb_pool_kxk_stream.sv
// Scoreboard bench: two DUT configs (7x7 K3 S2, 4x4 K2 S2) driven with directed
// and random frames; expected windows come from a frame-array reference model.
module tb_pool_kxk_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v_a, m_a, v_b, m_b;
  logic [31:0] p_a, p_b;
  logic [31:0] po_a, po_b;
  logic        vo_a, so_a, eo_a, vo_b, so_b, eo_b;

  pool_kxk_stream #(.DATA_WIDTH(32), .IMG_W(7), .IMG_H(7), .K(3), .S(2)) dut_a (
    .clk(clk), .reset(reset), .valid_in(v_a), .pxl_in(p_a), .mode(m_a),
    .pxl_out(po_a), .valid_out(vo_a), .sof_out(so_a), .eof_out(eo_a));

  pool_kxk_stream #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4), .K(2), .S(2)) dut_b (
    .clk(clk), .reset(reset), .valid_in(v_b), .pxl_in(p_b), .mode(m_b),
    .pxl_out(po_b), .valid_out(vo_b), .sof_out(so_b), .eof_out(eo_b));

  typedef struct {
    int  val;
    bit  sof;
    bit  eof;
    int  cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int img_w(input int d); return (d == 0) ? 7 : 4; endfunction
  function automatic int ker(input int d);   return (d == 0) ? 3 : 2; endfunction
  function automatic int str(input int d);   return 2; endfunction

  task automatic set_in(input int d, input bit v, input logic [31:0] p, input bit m);
    if (d == 0) begin v_a = v; p_a = p; m_a = m; end
    else        begin v_b = v; p_b = p; m_b = m; end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // kind: 0 = r*W+c, 1 = -(r*W+c), 2 = random; gap: 0 none, 1 every other, 2 random
  task automatic run_frame(input int d, input bit fmode, input int kind, input int gap,
                           input bit toggle, input int limit);
    int w, k, s, o, g, n, best, last;
    int img[7][7];
    exp_t e;
    w = img_w(d); k = ker(d); s = str(d);
    o = (w - k) / s + 1;
    last = k - 1 + (o - 1) * s;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = (kind == 0) ? r*w + c : (kind == 1) ? -(r*w + c) : int'($urandom);
    n = 0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n >= limit) return;
        g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
          set_in(d, 1'b0, $urandom, $urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
        set_in(d, 1'b1, img[r][c], (r == 0 && c == 0) ? fmode : (toggle ? !fmode : fmode));
        @(posedge clk); #1;
        if (r >= k-1 && c >= k-1 && (r-k+1) % s == 0 && (c-k+1) % s == 0) begin
          best = img[r-k+1][c-k+1];
          for (int i = r-k+1; i <= r; i++)
            for (int j = c-k+1; j <= c; j++)
              if (fmode ? (img[i][j] < best) : (img[i][j] > best)) best = img[i][j];
          e.val = best;
          e.sof = (r == k-1 && c == k-1);
          e.eof = (r == last && c == last);
          e.cyc = cyc + 2;
          push_exp(d, e);
        end
        n++;
      end
    end
  endtask

  task automatic idle(input int n);
    set_in(0, 1'b0, 32'h0, 1'b0);
    set_in(1, 1'b0, 32'h0, 1'b0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    idle(0);
    for (int i = 0; i < 40; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: pending a=%0d b=%0d required 0", name, qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    idle(4);
  endtask

  task automatic chk_rst(input string name);
    n_tests++;
    if (vo_a !== 1'b0 || so_a !== 1'b0 || eo_a !== 1'b0 || po_a !== 32'h0 ||
        vo_b !== 1'b0 || so_b !== 1'b0 || eo_b !== 1'b0 || po_b !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: a v/s/e/p=%b%b%b/%0h b v/s/e/p=%b%b%b/%0h required all 0",
               name, vo_a, so_a, eo_a, po_a, vo_b, so_b, eo_b, po_b);
    end
  endtask

  task automatic chk(input int d, input logic v, input logic [31:0] p,
                     input logic so, input logic eo);
    exp_t e;
    if (v !== 1'b1) begin
      if (so !== 1'b0 || eo !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL flags_idle dut%0d cyc=%0d sof=%b eof=%b required 0", d, cyc, so, eo);
      end
      return;
    end
    n_tests++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_out dut%0d cyc=%0d got %0d required no output", d, cyc, $signed(p));
      return;
    end
    e = (d == 0) ? qa.pop_front() : qb.pop_front();
    if ($signed(p) != e.val || so !== e.sof || eo !== e.eof || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL pool_out dut%0d got val=%0d sof=%b eof=%b cyc=%0d required val=%0d sof=%b eof=%b cyc=%0d",
               d, $signed(p), so, eo, cyc, e.val, e.sof, e.eof, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    chk(0, vo_a, po_a, so_a, eo_a);
    chk(1, vo_b, po_b, so_b, eo_b);
  end

  initial begin
    int rst_cyc;
    exp_t keep[$];
    reset = 1'b1;
    set_in(0, 1'b0, 32'h0, 1'b0);
    set_in(1, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset_state");
    reset = 1'b0;
    idle(2);

    run_frame(0, 1'b0, 0, 0, 1'b0, 999); drain("t1_max");
    run_frame(0, 1'b1, 0, 0, 1'b0, 999); drain("t2_min");
    run_frame(0, 1'b0, 1, 0, 1'b0, 999); drain("t3_neg");
    run_frame(1, 1'b0, 0, 0, 1'b0, 999);
    run_frame(1, 1'b1, 0, 0, 1'b1, 999); drain("t4_b2b");
    run_frame(0, 1'b0, 0, 1, 1'b0, 999); drain("t5_gaps");

    // Reset mid-frame: outputs due on or after the reset edge must vanish
    run_frame(0, 1'b0, 0, 0, 1'b0, 20);
    set_in(0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    rst_cyc = cyc + 1;
    keep.delete();
    foreach (qa[i]) if (qa[i].cyc < rst_cyc) keep.push_back(qa[i]);
    qa = keep;
    @(posedge clk); #1;
    chk_rst("reset_mid");
    reset = 1'b0;
    run_frame(0, 1'b0, 0, 0, 1'b0, 999); drain("t6_after_reset");

    for (int t = 0; t < 8; t++) begin
      run_frame(t % 2, $urandom_range(0, 1) == 1, 2, 2, $urandom_range(0, 1) == 1, 999);
      run_frame(t % 2, $urandom_range(0, 1) == 1, 2, (t < 4) ? 0 : 2, 1'b1, 999);
      drain("t7_random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
